// File: rtl/branch_recovery_ctrl.sv
// EX-stage misprediction recovery: redirect, front-end flush window and a single predictor-update pulse.
// Optional performance counters are enabled by defining BRC_PERF_CNT_EN.
module branch_recovery_ctrl #(
    parameter int PC_BITS      = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_BITS     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               EX_valid,
    input  logic               EX_brn,
    input  logic [PC_BITS-1:0] EX_pc,
    input  logic [PC_BITS-1:0] EX_alu_out,
    input  logic               EX_true_taken,
    input  logic               EX_pred_taken,
    input  logic [PC_BITS-1:0] EX_pred_target,
    input  logic               MEM_stall,
    output logic               redirect_valid,
    output logic [PC_BITS-1:0] redirect_pc,
    output logic               flush_front,
    output logic               bp_upd_en,
    output logic               mispredict,
    output logic [31:0]        perf_branches,
    output logic [31:0]        perf_mispredicts
);
    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(FLUSH_CYCLES - 1);

    state_t              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;
    logic [PC_BITS-1:0]  pend_pc_q;
    logic                resolve;
    logic                fire;
    logic [PC_BITS-1:0]  correct_pc;

    assign resolve    = EX_valid & EX_brn & (state_q != FLUSH);
    assign mispredict = resolve & ((EX_pred_taken != EX_true_taken) |
                                   (EX_true_taken & (EX_pred_target != EX_alu_out)));
    assign correct_pc = EX_true_taken ? EX_alu_out : EX_pc + PC_BITS'(4);
    assign cnt_d      = cnt_q - CNT_BITS'(1);

    // A redirect fires either immediately from IDLE or on the release of a stalled one.
    assign fire = ((state_q == IDLE) & mispredict & ~MEM_stall) |
                  ((state_q == PEND) & ~MEM_stall);

    always_comb begin
        redirect_valid = fire;
        flush_front    = fire | (state_q == FLUSH);
        bp_upd_en      = ((state_q == IDLE) & resolve & ~MEM_stall) |
                         ((state_q == PEND) & ~MEM_stall);
        redirect_pc    = '0;
        if (state_q == PEND)
            redirect_pc = pend_pc_q;
        else if (fire)
            redirect_pc = correct_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_pc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mispredict && !MEM_stall) begin
                        state_q <= (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
                        cnt_q   <= CNT_INIT;
                    end else if (mispredict && MEM_stall) begin
                        state_q   <= PEND;
                        pend_pc_q <= correct_pc;
                    end
                end
                PEND: begin
                    if (!MEM_stall) begin
                        state_q <= (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
                        cnt_q   <= CNT_INIT;
                    end
                end
                FLUSH: begin
                    // Counter holds the squash cycles still owed, this one included.
                    if (!MEM_stall) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == '0)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BRC_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (bp_upd_en)
                perf_br_q <= perf_br_q + 32'd1;
            if (redirect_valid)
                perf_mp_q <= perf_mp_q + 32'd1;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
`else
    assign perf_branches    = 32'd0;
    assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed plus random bench for branch_recovery_ctrl against a transaction-level recovery model.
module tb_branch_recovery_ctrl;
    localparam int FC = 2;
`ifdef BRC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_brn, ex_true_taken, ex_pred_taken, mem_stall;
    logic [31:0] ex_pc, ex_alu_out, ex_pred_target;
    logic        redirect_valid, flush_front, bp_upd_en, mispredict;
    logic [31:0] redirect_pc, perf_branches, perf_mispredicts;

    int errors = 0;
    int checks = 0;

    // Model: outstanding redirect (pending pc), squash cycles still owed, event counts.
    bit          m_pend;
    logic [31:0] m_pend_pc;
    int          m_flush_left;
    logic [31:0] m_br, m_mp;

    branch_recovery_ctrl #(.PC_BITS(32), .FLUSH_CYCLES(FC), .CNT_BITS(3)) dut (
        .clk(clk), .rst(rst),
        .EX_valid(ex_valid), .EX_brn(ex_brn), .EX_pc(ex_pc), .EX_alu_out(ex_alu_out),
        .EX_true_taken(ex_true_taken), .EX_pred_taken(ex_pred_taken),
        .EX_pred_target(ex_pred_target), .MEM_stall(mem_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_front(flush_front), .bp_upd_en(bp_upd_en), .mispredict(mispredict),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs at negedge, check outputs, then advance the model for the posedge.
    task automatic step(input bit r, input bit v, input bit b, input logic [31:0] pc,
                        input logic [31:0] alu, input bit tt, input bit pt,
                        input logic [31:0] ptgt, input bit st);
        bit          in_flush, res, mis, e_rv, e_ff, e_upd;
        logic [31:0] cpc, e_rpc;
        @(negedge clk);
        rst = r; ex_valid = v; ex_brn = b; ex_pc = pc; ex_alu_out = alu;
        ex_true_taken = tt; ex_pred_taken = pt; ex_pred_target = ptgt; mem_stall = st;
        #1;
        in_flush = (m_flush_left > 0);
        res = v && b && !in_flush;
        mis = res && ((pt != tt) || (tt && ptgt != alu));
        cpc = tt ? alu : pc + 32'd4;
        e_rv = 0; e_ff = 0; e_upd = 0; e_rpc = 32'd0;
        if (in_flush) begin
            e_ff = 1;
        end else if (m_pend) begin
            e_rpc = m_pend_pc;
            if (!st) begin e_rv = 1; e_ff = 1; e_upd = 1; end
        end else if (res && !st) begin
            e_upd = 1;
            if (mis) begin e_rv = 1; e_ff = 1; e_rpc = cpc; end
        end
        if (!r) begin
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
            chk("redirect_pc", redirect_pc, e_rpc);
            chk("flush_front", {31'd0, flush_front}, {31'd0, e_ff});
            chk("bp_upd_en", {31'd0, bp_upd_en}, {31'd0, e_upd});
            chk("mispredict", {31'd0, mispredict}, {31'd0, mis});
            chk("perf_branches", perf_branches, PERF ? m_br : 32'd0);
            chk("perf_mispredicts", perf_mispredicts, PERF ? m_mp : 32'd0);
        end
        if (r) begin
            m_pend = 0; m_pend_pc = 0; m_flush_left = 0; m_br = 0; m_mp = 0;
        end else begin
            if (e_upd) m_br = m_br + 32'd1;
            if (e_rv)  m_mp = m_mp + 32'd1;
            if (in_flush) begin
                if (!st) m_flush_left--;
            end else if (e_rv) begin
                m_pend = 0;
                m_flush_left = FC - 1;
            end else if (!m_pend && mis && st) begin
                m_pend = 1;
                m_pend_pc = cpc;
            end
        end
    endtask

    task automatic idle_step();
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        bit          v, b, tt, pt, st, r;
        logic [31:0] pc, alu, ptgt;
        m_pend = 0; m_pend_pc = 0; m_flush_left = 0; m_br = 0; m_mp = 0;
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        idle_step();
        chk("reset_flush_front", {31'd0, flush_front}, 32'd0);

        // Correct prediction updates without redirect
        step(0, 1, 1, 32'h100, 32'h200, 1, 1, 32'h200, 0);
        chk("correct_upd", {31'd0, bp_upd_en}, 32'd1);
        idle_step();

        // Direction mispredict, then a wrong-path branch during FLUSH
        step(0, 1, 1, 32'h100, 32'h200, 0, 1, 32'h200, 0);
        chk("dir_rpc", redirect_pc, 32'h104);
        step(0, 1, 1, 32'h104, 32'h400, 1, 0, 32'h108, 0);
        chk("dir_flush2", {31'd0, flush_front}, 32'd1);
        idle_step();
        chk("dir_flush_end", {31'd0, flush_front}, 32'd0);

        // Target mispredict
        step(0, 1, 1, 32'h100, 32'h200, 1, 1, 32'h300, 0);
        chk("tgt_rpc", redirect_pc, 32'h200);
        idle_step();
        idle_step();

        // Mispredict under a 3-cycle MEM stall
        step(0, 1, 1, 32'h500, 32'h800, 1, 0, 32'h504, 1);
        step(0, 1, 1, 32'h500, 32'h800, 1, 0, 32'h504, 1);
        step(0, 1, 1, 32'h500, 32'h800, 1, 0, 32'h504, 1);
        step(0, 1, 1, 32'h500, 32'h800, 1, 0, 32'h504, 0);
        chk("stall_rpc", redirect_pc, 32'h800);
        idle_step();
        idle_step();

        // Fall-through wrap at the top of the address space
        step(0, 1, 1, 32'hFFFF_FFFC, 32'h40, 0, 1, 32'h40, 0);
        chk("wrap_rpc", redirect_pc, 32'h0);
        chk("wrap_rv", {31'd0, redirect_valid}, 32'd1);
        idle_step();
        idle_step();

        // Reset in the first FLUSH cycle abandons the squash
        step(0, 1, 1, 32'h100, 32'h200, 0, 1, 32'h200, 0);
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        idle_step();
        chk("rst_flush", {31'd0, flush_front}, 32'd0);

        // Five branches with two mispredicts, for the counters
        step(0, 1, 1, 32'h10, 32'h20, 1, 1, 32'h20, 0);
        step(0, 1, 1, 32'h14, 32'h20, 0, 0, 32'h20, 0);
        step(0, 1, 1, 32'h18, 32'h40, 1, 0, 32'h1C, 0);
        idle_step();
        step(0, 1, 1, 32'h40, 32'h80, 1, 1, 32'h80, 0);
        step(0, 1, 1, 32'h44, 32'h90, 0, 1, 32'h90, 0);
        idle_step();
        idle_step();
        if (PERF) begin
            chk("perf_br5", perf_branches, 32'd5);
            chk("perf_mp2", perf_mispredicts, 32'd2);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            v   = ($urandom_range(0, 3) != 0);
            b   = ($urandom_range(0, 2) != 0);
            pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} ^ ($urandom_range(0, 9) == 0 ? 32'hFFFF_FFF0 : 32'h0);
            alu = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            tt  = $urandom_range(0, 1);
            pt  = ($urandom_range(0, 3) == 0) ? ~tt : tt;
            ptgt = ($urandom_range(0, 4) == 0) ? alu + 32'd4 : alu;
            st  = ($urandom_range(0, 9) < 4);
            step(r, v, b, pc, alu, tt, pt, ptgt, st);
        end

        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        idle_step();
        chk("final_perf_clear", perf_branches, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
